// File: rtl/mod_counter_pkg.sv
// Shared constants for the modulo counter: default geometry, direction
// encodings and a helper that sizes the prescaler phase register.
package mod_counter_pkg;

    localparam int DEF_WIDTH     = 12;
    localparam int DEF_MAX       = 4095;
    localparam int DEF_PRESC_DIV = 1;

    // Direction encodings for the up input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of a phase register that can hold 0..div-1 (at least one bit).
    function automatic int phase_width(input int div);
        if (div > 1) begin
            return $clog2(div);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mod_counter_presc.sv
// Count-tick prescaler: emits a one-cycle tick on every PRESC_DIV-th
// enabled cycle. Restart forces the phase back to zero and suppresses the
// tick in that cycle, so a load or clear always starts a fresh division.
module mod_counter_presc
    import mod_counter_pkg::*;
#(
    parameter int PRESC_DIV = DEF_PRESC_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    localparam int            PW   = phase_width(PRESC_DIV);
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] phase_r;
    logic [PW-1:0] phase_s;
    logic          tick_s;

    // Next phase and tick decode; phase holds while the count is disabled.
    always_comb begin
        phase_s = phase_r;
        tick_s  = 1'b0;
        if (restart) begin
            phase_s = '0;
        end else if (enable) begin
            if (phase_r == LAST) begin
                phase_s = '0;
                tick_s  = 1'b1;
            end else begin
                phase_s = phase_r + PW'(1);
            end
        end else begin
            phase_s = phase_r;
        end
    end

    // Phase register; reset discards any partially accumulated division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_s;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter (modulo MAX+1) with prescaled count ticks,
// synchronous clear and load, a one-cycle terminal-count pulse on wrap and
// a sticky wrap flag. Optional feature macro MOD_COUNTER_SAT_EN adds a
// sat input that turns boundary ticks into holds instead of wraps.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int          WIDTH     = DEF_WIDTH,
    parameter int unsigned MAX       = DEF_MAX,
    parameter int          PRESC_DIV = DEF_PRESC_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             tc_r;
    logic             tc_s;
    logic             ovf_r;
    logic             ovf_s;
    logic             tick_s;
    logic             restart_s;
    logic             sat_s;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_s = sat;
`else
    assign sat_s = 1'b0;
`endif

    // Clear and load both restart the prescaler so the next tick is a full
    // PRESC_DIV enabled cycles away.
    assign restart_s = clr | load;

    mod_counter_presc #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .restart (restart_s),
        .tick    (tick_s)
    );

    // Next-state decode with priority clear > load > tick; tc defaults low so
    // it can only be high for the single cycle after a wrap.
    always_comb begin
        count_s = count_r;
        tc_s    = 1'b0;
        ovf_s   = ovf_r;
        if (clr) begin
            count_s = '0;
            ovf_s   = 1'b0;
        end else if (load) begin
            count_s = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (tick_s) begin
            if (up == DIR_UP) begin
                if (count_r >= MAX_V) begin
                    ovf_s = 1'b1;
                    if (sat_s) begin
                        count_s = count_r;
                    end else begin
                        count_s = '0;
                        tc_s    = 1'b1;
                    end
                end else begin
                    count_s = count_r + WIDTH'(1);
                end
            end else begin
                if (count_r == '0) begin
                    ovf_s = 1'b1;
                    if (sat_s) begin
                        count_s = count_r;
                    end else begin
                        count_s = MAX_V;
                        tc_s    = 1'b1;
                    end
                end else begin
                    count_s = count_r - WIDTH'(1);
                end
            end
        end else begin
            count_s = count_r;
        end
    end

    // Output registers; asynchronous reset clears count and both flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_s;
            tc_r    <= tc_s;
            ovf_r   <= ovf_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter. Three instances cover the default
// geometry (12 bit, MAX 4095, no prescale), a MAX=9 counter and a MAX=9
// counter with a divide-by-4 prescaler. Expected results are queued when a
// cycle's stimulus is applied and popped when the DUT has produced it.
`timescale 1ns/1ps
module tb_mod_counter;

    typedef struct packed {
        logic        e;
        logic        u;
        logic        c;
        logic        l;
        logic [11:0] lv;
        logic [11:0] cnt;
        logic        tc;
        logic        ovf;
    } row_t;

    typedef struct packed {
        int          d;
        logic [11:0] cnt;
        logic        tc;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en   [3];
    logic        up   [3];
    logic        clr  [3];
    logic        load [3];
    logic        tc   [3];
    logic        ovf  [3];
    logic [11:0] lv_a;
    logic [3:0]  lv_b;
    logic [3:0]  lv_c;
    logic [11:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [3:0]  cnt_c;
    logic        sat_b;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(12), .MAX(4095), .PRESC_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .up(up[0]), .clr(clr[0]),
        .load(load[0]), .load_val(lv_a),
`ifdef MOD_COUNTER_SAT_EN
        .sat(1'b0),
`endif
        .count(cnt_a), .tc(tc[0]), .ovf(ovf[0]));

    mod_counter #(.WIDTH(4), .MAX(9), .PRESC_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .up(up[1]), .clr(clr[1]),
        .load(load[1]), .load_val(lv_b),
`ifdef MOD_COUNTER_SAT_EN
        .sat(sat_b),
`endif
        .count(cnt_b), .tc(tc[1]), .ovf(ovf[1]));

    mod_counter #(.WIDTH(4), .MAX(9), .PRESC_DIV(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .up(up[2]), .clr(clr[2]),
        .load(load[2]), .load_val(lv_c),
`ifdef MOD_COUNTER_SAT_EN
        .sat(1'b0),
`endif
        .count(cnt_c), .tc(tc[2]), .ovf(ovf[2]));

    function automatic row_t mk(input int e, input int u, input int c, input int l,
                                input int lv, input int cnt, input int t, input int o);
        row_t r;
        r.e   = (e != 0);
        r.u   = (u != 0);
        r.c   = (c != 0);
        r.l   = (l != 0);
        r.lv  = 12'(lv);
        r.cnt = 12'(cnt);
        r.tc  = (t != 0);
        r.ovf = (o != 0);
        return r;
    endfunction

    function automatic logic [13:0] actual(input int d);
        case (d)
            0:       return {cnt_a, tc[0], ovf[0]};
            1:       return {8'd0, cnt_b, tc[1], ovf[1]};
            default: return {8'd0, cnt_c, tc[2], ovf[2]};
        endcase
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            en[i]   = 1'b0;
            clr[i]  = 1'b0;
            load[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus on instance d (others idle) and queue its result.
    task automatic apply(input int d, input row_t r);
        idle_all();
        en[d]   = r.e;
        up[d]   = r.u;
        clr[d]  = r.c;
        load[d] = r.l;
        case (d)
            0:       lv_a = r.lv;
            1:       lv_b = r.lv[3:0];
            default: lv_c = r.lv[3:0];
        endcase
        sb.push_back('{d, r.cnt, r.tc, r.ovf});
    endtask

    task automatic test_reset();
        exp_t        x;
        logic [13:0] act;
        rst_n = 1'b0;
        idle_all();
        for (int i = 0; i < 3; i++) up[i] = 1'b1;
        lv_a = 12'd0; lv_b = 4'd0; lv_c = 4'd0; sat_b = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            sb.push_back('{d, 12'd0, 1'b0, 1'b0});
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL reset dut%0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         d, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_up();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        q.push_back(mk(0,1,0,1,4094, 4094,0,0));
        q.push_back(mk(1,1,0,0,0,    4095,0,0));
        q.push_back(mk(1,1,0,0,0,    0,   1,1));
        q.push_back(mk(1,1,0,0,0,    1,   0,1));
        q.push_back(mk(0,1,0,0,0,    1,   0,1));
        q.push_back(mk(1,0,0,0,0,    0,   0,1));
        q.push_back(mk(1,0,0,0,0,    4095,1,1));
        q.push_back(mk(1,0,0,0,0,    4094,0,1));
        q.push_back(mk(0,1,1,0,0,    0,   0,0));
        foreach (q[i]) begin
            apply(0, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL wrap_up step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

    task automatic test_wrap_down();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        q.push_back(mk(1,0,0,0,0, 9,1,1));
        q.push_back(mk(0,0,1,0,0, 0,0,0));
        q.push_back(mk(1,0,0,0,0, 9,1,1));
        q.push_back(mk(1,0,0,0,0, 8,0,1));
        q.push_back(mk(0,0,0,0,0, 8,0,1));
        q.push_back(mk(0,1,1,0,0, 0,0,0));
        foreach (q[i]) begin
            apply(1, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL wrap_down step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

    task automatic test_prescaler();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        q.push_back(mk(0,1,1,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(0,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 1,0,0));
        q.push_back(mk(1,1,0,0,0, 1,0,0));
        q.push_back(mk(1,1,0,0,0, 1,0,0));
        q.push_back(mk(1,1,0,1,3, 3,0,0));
        q.push_back(mk(1,1,0,0,0, 3,0,0));
        q.push_back(mk(1,1,0,0,0, 3,0,0));
        q.push_back(mk(1,1,0,0,0, 3,0,0));
        q.push_back(mk(1,1,0,0,0, 4,0,0));
        q.push_back(mk(0,1,0,1,9, 9,0,0));
        q.push_back(mk(1,1,0,0,0, 9,0,0));
        q.push_back(mk(1,1,0,0,0, 9,0,0));
        q.push_back(mk(1,1,0,0,0, 9,0,0));
        q.push_back(mk(1,1,0,0,0, 0,1,1));
        q.push_back(mk(1,1,0,0,0, 0,0,1));
        q.push_back(mk(0,1,1,0,0, 0,0,0));
        foreach (q[i]) begin
            apply(2, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL prescaler step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

    task automatic test_load();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        q.push_back(mk(0,1,0,1,15, 9,0,0));
        q.push_back(mk(0,1,1,1,3,  0,0,0));
        q.push_back(mk(1,1,0,1,9,  9,0,0));
        q.push_back(mk(1,1,0,1,0,  0,0,0));
        q.push_back(mk(1,0,0,1,5,  5,0,0));
        q.push_back(mk(1,1,0,0,0,  6,0,0));
        foreach (q[i]) begin
            apply(1, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL load step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        int          m = 6;
        int          o = 0;
        int          t;
        for (int k = 0; k < 18; k++) begin
            if (k < 12) begin
                t = (m == 9) ? 1 : 0;
                m = (m == 9) ? 0 : m + 1;
            end else begin
                t = (m == 0) ? 1 : 0;
                m = (m == 0) ? 9 : m - 1;
            end
            if (t != 0) o = 1;
            q.push_back(mk(1, (k < 12) ? 1 : 0, 0, 0, 0, m, t, o));
        end
        foreach (q[i]) begin
            apply(1, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL back_to_back step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        // Put dut_c two enabled cycles into its divide-by-4, then load dut_b to 7.
        apply(2, mk(1,1,0,0,0, 0,0,0));
        @(posedge clk); #1;
        void'(sb.pop_front());
        apply(2, mk(1,1,0,0,0, 0,0,0));
        @(posedge clk); #1;
        void'(sb.pop_front());
        apply(1, mk(0,1,0,1,7, 7,0,1));
        @(posedge clk); #1;
        x = sb.pop_front();
        act = actual(x.d);
        checks++;
        if (act !== {x.cnt, x.tc, x.ovf}) begin
            failures++;
            $display("FAIL async_reset preload: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
        end
        idle_all();
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            sb.push_back('{d, 12'd0, 1'b0, 1'b0});
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL async_reset dut%0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         d, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 0,0,0));
        q.push_back(mk(1,1,0,0,0, 1,0,0));
        foreach (q[i]) begin
            apply(2, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL presc_after_reset step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
    endtask

`ifdef MOD_COUNTER_SAT_EN
    task automatic test_saturate();
        row_t        q[$];
        exp_t        x;
        logic [13:0] act;
        q.push_back(mk(0,1,0,1,9, 9,0,0));
        q.push_back(mk(1,1,0,0,0, 9,0,1));
        q.push_back(mk(1,1,0,0,0, 9,0,1));
        q.push_back(mk(0,0,0,1,0, 0,0,1));
        q.push_back(mk(1,0,0,0,0, 0,0,1));
        foreach (q[i]) begin
            sat_b = 1'b1;
            apply(1, q[i]);
            @(posedge clk); #1;
            x = sb.pop_front();
            act = actual(x.d);
            checks++;
            if (act !== {x.cnt, x.tc, x.ovf}) begin
                failures++;
                $display("FAIL saturate step %0d: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                         i, act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
            end
        end
        sat_b = 1'b0;
        apply(1, mk(1,0,0,0,0, 9,1,1));
        @(posedge clk); #1;
        x = sb.pop_front();
        act = actual(x.d);
        checks++;
        if (act !== {x.cnt, x.tc, x.ovf}) begin
            failures++;
            $display("FAIL sat_off_wrap: got cnt=%0d tc=%0b ovf=%0b, expected cnt=%0d tc=%0b ovf=%0b",
                     act[13:2], act[1], act[0], x.cnt, x.tc, x.ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_prescaler();
        test_load();
        test_back_to_back();
        test_async_reset();
`ifdef MOD_COUNTER_SAT_EN
        test_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 12, SHALL set the counter width in bits (legal range 2..32).
REQ-003 Parameter MAX, default 4095, SHALL set the terminal value; legal range 1..2^WIDTH-1; counting is modulo MAX+1.
REQ-004 Parameter PRESC_DIV, default 1, SHALL set the count-tick divider; legal range 1..256.
REQ-005 CLK  in  1  clock; all state changes on the rising edge.
REQ-006 RST  in  1  asynchronous, active-low reset.
REQ-007 ENABLE  in  1  count enable; gates both the prescaler and the counter.
REQ-008 UP  in  1  direction: 1 counts up, 0 counts down.
REQ-009 CLR  in  1  synchronous clear.
REQ-010 LOAD  in  1  synchronous load strobe.
REQ-011 LOAD_VAL  in  WIDTH  value to load.
REQ-012 COUNT  out  WIDTH  registered count value.
REQ-013 TC  out  1  registered one-cycle terminal-count pulse.
REQ-014 OVF  out  1  sticky wrap flag.

Function
REQ-015 Per-cycle priority SHALL be: CLR, then LOAD, then count.
REQ-016 CLR=1 SHALL set COUNT=0, OVF=0, TC=0 and the prescaler phase to 0 on the next edge.
REQ-017 LOAD=1 (CLR=0) SHALL set COUNT=min(LOAD_VAL, MAX), TC=0, prescaler phase 0; ENABLE is ignored that cycle.
REQ-018 A tick SHALL occur on a cycle with ENABLE=1 and prescaler phase = PRESC_DIV-1; the phase then returns to 0, otherwise it increments; phase holds while ENABLE=0.
REQ-019 With PRESC_DIV=1, every cycle with ENABLE=1 SHALL be a tick.
REQ-020 On a tick with UP=1: COUNT<MAX -> COUNT+1; COUNT=MAX -> 0 (wrap).
REQ-021 On a tick with UP=0: COUNT>0 -> COUNT-1; COUNT=0 -> MAX (wrap).
REQ-022 A wrap SHALL make TC=1 for exactly the one cycle in which COUNT shows the post-wrap value, and SHALL set OVF=1.
REQ-023 TC SHALL be 0 in all other cycles; OVF SHALL clear only on CLR or reset.
REQ-024 UP changes SHALL take effect on the next tick without a pipeline delay; there is no latency beyond one edge from tick to COUNT.
REQ-025 Simultaneous LOAD and a tick SHALL produce no TC, even when COUNT was at a boundary.

Reset
REQ-026 RST=0 SHALL immediately force COUNT=0, TC=0, OVF=0 and prescaler phase 0, independent of CLK.
REQ-027 Assertion of RST mid-tick or mid-prescale SHALL discard that partial state; the first tick after release SHALL come PRESC_DIV enabled cycles later.

Configuration
REQ-028 Macro MOD_COUNTER_SAT_EN, when defined, SHALL add input SAT (1 bit); with SAT=1 a tick at the boundary (MAX going up, 0 going down) SHALL hold COUNT, keep TC=0 and set OVF=1.
REQ-029 With SAT=0, or with MOD_COUNTER_SAT_EN undefined (no SAT port), the block SHALL wrap per REQ-020..022.

Structure
REQ-030 Package mod_counter_pkg SHALL hold the default WIDTH/MAX/PRESC_DIV constants and the UP/DOWN direction constants.
REQ-031 The prescaler SHALL be a sub-module, mod_counter_presc, with inputs CLK, RST, ENABLE and a restart input, and a one-cycle tick output.

Verification
REQ-032 WIDTH=12, MAX=4095, PRESC_DIV=1, UP=1, ENABLE=1 from 4094 -> COUNT 4095, then 0 with TC=1 for one cycle, then OVF=1 sticky.
REQ-033 MAX=9, UP=0, from COUNT=0 with one tick -> COUNT=9, TC=1; CLR next cycle -> COUNT=0, OVF=0.
REQ-034 PRESC_DIV=4, ENABLE toggled 1,1,0,1,1 -> COUNT increments once, on the fourth enabled cycle only.
REQ-035 MAX=9, LOAD=1 with LOAD_VAL=15 -> COUNT=9; LOAD and CLR together -> COUNT=0.
REQ-036 RST pulsed low between edges at COUNT=7 -> COUNT=0, TC=0, OVF=0 before the next edge.
REQ-037 With MOD_COUNTER_SAT_EN defined, SAT=1, MAX=9, UP=1 at 9 -> COUNT stays 9, TC=0, OVF=1.
